regfile_scoreboard: RTL and testbench

Parametrised multi-port register file with an integrated per-register pending-write scoreboard, for the next-generation pipeline. It generalises the current 2R/1W register file to NRD read ports and NWR write ports, with optional write-to-read bypass. It also tracks in-flight destination writes so decode can detect RAW hazards and stall. It sits between decode (read, issue) and writeback (write).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rf_pend_counter.sv | 47 ++++
 rtl/regfile_scoreboard.sv | 123 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, pending-count type and width helper for the
// multi-port register file with pending-write scoreboard.
package regfile_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREG   = 32;
    localparam int PEND_W_MAX = 16;

    typedef logic [PEND_W_MAX-1:0] pend_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_pend_counter.sv
// Per-register count of in-flight writes: one reservation in,
// up to NWR retirements out per cycle, saturating at zero.
module rf_pend_counter
    import regfile_pkg::*;
#(
    parameter int PEND_MAX = 3,
    parameter int NWR      = 1,
    parameter int PW       = clog2(PEND_MAX + 1),
    parameter int DW       = clog2(NWR + 1)
) (
    input  logic          ctrl_clk,
    input  logic          ctrl_reset_n,
    input  logic          inc,
    input  logic [DW-1:0] dec,
    output logic [PW-1:0] cnt,
    output logic          busy_after_dec,
    output logic          full,
    output logic          underflow
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    pend_t         sum;

    always_comb begin
        sum            = pend_t'(cnt_q) + pend_t'(inc);
        underflow      = 1'b0;
        cnt_d          = PW'(sum - pend_t'(dec));
        if (sum < pend_t'(dec)) begin
            underflow = 1'b1;
            cnt_d     = '0;
        end
        busy_after_dec = pend_t'(cnt_q) > pend_t'(dec);
        full           = (cnt_q == PW'(PEND_MAX));
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// NRD-read / NWR-write register file with optional write bypass and
// a per-register pending-write scoreboard for RAW hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int PEND_MAX = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = clog2(NREG)
) (
    input  logic                ctrl_clk,
    input  logic                ctrl_reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    output logic                issue_rdy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic                sb_err
);

    localparam int PW = clog2(PEND_MAX + 1);
    localparam int DW = clog2(NWR + 1);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [DW-1:0]   dec   [NREG];
    logic [PW-1:0]   cnt   [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] busy_ad;
    logic [NREG-1:0] full;
    logic [NREG-1:0] uflow;
    logic            sb_err_q;
    logic            sb_err_d;
    logic [AW-1:0]   wa;
    logic [AW-1:0]   ra;

    // Ascending port order makes the highest-index write win.
    always_comb begin
        mem_d = mem_q;
        wa    = '0;
        for (int r = 0; r < NREG; r++) begin
            dec[r] = '0;
        end
        for (int i = 0; i < NWR; i++) begin
            wa = wr_addr[i*AW +: AW];
            if (wr_en[i] && !(ZERO_REG != 0 && wa == '0)) begin
                mem_d[wa] = wr_data[i*XLEN +: XLEN];
                dec[wa]   = dec[wa] + DW'(1);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rd_addr[k*AW +: AW];
            rd_data[k*XLEN +: XLEN] = mem_q[ra];
            rd_busy[k] = (BYPASS != 0) ? busy_ad[ra] : (cnt[ra] != '0);
            if (BYPASS != 0) begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_en[i] && wr_addr[i*AW +: AW] == ra) begin
                        rd_data[k*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
                    end
                end
            end
            if (ZERO_REG != 0 && ra == '0) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_busy[k]              = 1'b0;
            end
        end
    end

    // Readiness looks only at the registered count, never at writes.
    always_comb begin
        issue_rdy = (ZERO_REG != 0 && issue_addr == '0) || !full[issue_addr];
        for (int r = 0; r < NREG; r++) begin
            inc[r] = issue_en && issue_rdy && issue_addr == AW'(r)
                     && !(ZERO_REG != 0 && r == 0);
        end
        sb_err_d = sb_err_q | (|uflow);
    end

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        rf_pend_counter #(
            .PEND_MAX (PEND_MAX),
            .NWR      (NWR),
            .PW       (PW),
            .DW       (DW)
        ) u_cnt (
            .ctrl_clk       (ctrl_clk),
            .ctrl_reset_n   (ctrl_reset_n),
            .inc            (inc[g]),
            .dec            (dec[g]),
            .cnt            (cnt[g]),
            .busy_after_dec (busy_ad[g]),
            .full           (full[g]),
            .underflow      (uflow[g])
        );
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            mem_q    <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus pushes expected outputs, a monitor on the
// falling edge pops and compares them against the DUT.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                ctrl_clk;
    logic                ctrl_reset_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic                issue_rdy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                sb_err;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp;
    int   n_bad;

    regfile_scoreboard #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NRD      (NRD),
        .NWR      (NWR),
        .PEND_MAX (3),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .ctrl_clk     (ctrl_clk),
        .ctrl_reset_n (ctrl_reset_n),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .issue_en     (issue_en),
        .issue_addr   (issue_addr),
        .issue_rdy    (issue_rdy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sb_err       (sb_err)
    );

    initial begin
        ctrl_clk = 1'b0;
        forever #5 ctrl_clk = ~ctrl_clk;
    end

    always @(negedge ctrl_clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if ({rd_data, rd_busy, issue_rdy, sb_err}
                !== {e.d1, e.d0, e.busy, e.rdy, e.err}) begin
                n_bad++;
                $display("FAIL %s: got d0=%h d1=%h busy=%b rdy=%b err=%b want d0=%h d1=%h busy=%b rdy=%b err=%b",
                         e.name, rd_data[31:0], rd_data[63:32], rd_busy,
                         issue_rdy, sb_err, e.d0, e.d1, e.busy, e.rdy, e.err);
            end
        end
    end

    task automatic cyc();
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic push(input string n, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] b,
                        input logic r, input logic er);
        exp_t x;
        x.name = n;
        x.d0   = d0;
        x.d1   = d1;
        x.busy = b;
        x.rdy  = r;
        x.err  = er;
        q.push_back(x);
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic iss(input logic en, input logic [4:0] a);
        issue_en   = en;
        issue_addr = a;
    endtask

    task automatic wr(input logic [1:0] en, input logic [4:0] a0,
                      input logic [31:0] d0, input logic [4:0] a1,
                      input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        ctrl_reset_n = 1'b0;
        rd(5, 5);
        iss(0, 5);
        wr(2'b00, 0, 0, 0, 0);
        cyc();
        cyc();
        ctrl_reset_n = 1'b1;
        push("reset_read", 0, 0, 2'b00, 1, 0);
        cyc();

        iss(1, 5);
        push("iss5_a", 0, 0, 2'b00, 1, 0);
        cyc();
        push("iss5_b", 0, 0, 2'b11, 1, 0);
        cyc();
        #2 ctrl_reset_n = 1'b0;
        push("rst_mid", 0, 0, 2'b00, 1, 0);
        cyc();
        ctrl_reset_n = 1'b1;
        iss(0, 5);
        push("post_rst", 0, 0, 2'b00, 1, 0);
        cyc();

        rd(3, 3);
        iss(1, 3);
        push("iss3", 0, 0, 2'b00, 1, 0);
        cyc();
        iss(0, 3);
        push("busy3", 0, 0, 2'b11, 1, 0);
        cyc();
        rd(3, 5);
        wr(2'b01, 3, 32'hDEADBEEF, 0, 0);
        push("byp3", 32'hDEADBEEF, 0, 2'b00, 1, 0);
        cyc();
        rd(3, 3);
        wr(2'b00, 0, 0, 0, 0);
        push("st3", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0);
        cyc();

        rd(7, 7);
        iss(1, 7);
        push("i7_1", 0, 0, 2'b00, 1, 0);
        cyc();
        push("i7_2", 0, 0, 2'b11, 1, 0);
        cyc();
        push("i7_3", 0, 0, 2'b11, 1, 0);
        cyc();
        push("i7_full", 0, 0, 2'b11, 0, 0);
        cyc();
        wr(2'b01, 7, 32'h77, 0, 0);
        push("i7_wr_full", 32'h77, 32'h77, 2'b11, 0, 0);
        cyc();
        iss(0, 7);
        wr(2'b00, 0, 0, 0, 0);
        push("rdy7", 32'h77, 32'h77, 2'b11, 1, 0);
        cyc();
        wr(2'b01, 7, 32'h78, 0, 0);
        push("w7", 32'h78, 32'h78, 2'b11, 1, 0);
        cyc();
        iss(1, 7);
        wr(2'b01, 7, 32'h79, 0, 0);
        push("net7", 32'h79, 32'h79, 2'b00, 1, 0);
        cyc();
        iss(0, 7);
        wr(2'b00, 0, 0, 0, 0);
        push("net7_hold", 32'h79, 32'h79, 2'b11, 1, 0);
        cyc();
        wr(2'b01, 7, 32'h7A, 0, 0);
        push("w7_last", 32'h7A, 32'h7A, 2'b00, 1, 0);
        cyc();
        wr(2'b00, 0, 0, 0, 0);
        push("z7", 32'h7A, 32'h7A, 2'b00, 1, 0);
        cyc();

        rd(9, 9);
        iss(1, 9);
        push("i9_1", 0, 0, 2'b00, 1, 0);
        cyc();
        push("i9_2", 0, 0, 2'b11, 1, 0);
        cyc();
        iss(0, 9);
        wr(2'b11, 9, 32'h11, 9, 32'h22);
        push("dual9", 32'h22, 32'h22, 2'b00, 1, 0);
        cyc();
        wr(2'b00, 0, 0, 0, 0);
        push("st9", 32'h22, 32'h22, 2'b00, 1, 0);
        cyc();

        rd(0, 0);
        iss(1, 0);
        wr(2'b01, 0, 32'hFFFFFFFF, 0, 0);
        push("zero_wr", 0, 0, 2'b00, 1, 0);
        cyc();
        iss(0, 0);
        wr(2'b00, 0, 0, 0, 0);
        push("zero_rd", 0, 0, 2'b00, 1, 0);
        cyc();

        rd(4, 9);
        iss(0, 4);
        wr(2'b10, 0, 0, 4, 32'hA5A5A5A5);
        push("uf4", 32'hA5A5A5A5, 32'h22, 2'b00, 1, 0);
        cyc();
        wr(2'b00, 0, 0, 0, 0);
        push("err4", 32'hA5A5A5A5, 32'h22, 2'b00, 1, 1);
        cyc();
        push("err_hold", 32'hA5A5A5A5, 32'h22, 2'b00, 1, 1);
        cyc();
        ctrl_reset_n = 1'b0;
        push("rst_err", 0, 0, 2'b00, 1, 0);
        cyc();
        ctrl_reset_n = 1'b1;
        cyc();
        cyc();

        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
